// File: rtl/eth_tx_pkg.sv
// Shared definitions for the transmit framer: CRC constants, framing
// lengths and the framer state encoding.
// The PAD state exists only when FCS_APPEND_PAD_EN is defined.
package eth_tx_pkg;

  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFF_FFFF;
  localparam int          PREAMBLE_DIBITS = 32;
  localparam int          FCS_DIBITS      = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
`ifdef FCS_APPEND_PAD_EN
    S_PAD  = 3'd3,
`endif
    S_FCS  = 3'd4,
    S_IFG  = 3'd5
  } tx_state_t;

endpackage

// File: rtl/crc32_dibit_step.sv
// Combinational reflected CRC-32 update for one dibit, bit0 shifted in first.
module crc32_dibit_step
  import eth_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_next
);

  logic [31:0] c;
  logic        fb;

  // Two serial LFSR shifts, LSB of the dibit first.
  always_comb begin
    c  = crc;
    fb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fb = c[0] ^ dibit[i];
      c  = c >> 1;
      if (fb) c = c ^ ETH_CRC_POLY;
    end
    crc_next = c;
  end

endmodule

// File: rtl/fcs_append.sv
// Transmit framer for the 2-bit RMII stream: preamble+SFD, payload with
// on-the-fly CRC-32, 32-bit FCS, then inter-frame gap.
// Optional minimum-length zero padding: define FCS_APPEND_PAD_EN.
//
// state | meaning
// IDLE  | waiting for axiiv
// PRE   | 28x 01, then 01 01 01 11 (SFD); ready on the last one
// DATA  | forwarding payload and folding it into the CRC
// PAD   | zero dibits up to the minimum length (optional)
// FCS   | 16 dibits of ~crc, LSB first
// IFG   | IFG_DIBITS idle cycles
//
// axiov/axiod are registered from the next-state decision, so the dibit
// shown during a given PRE/FCS cycle was chosen one cycle earlier.  That
// lets the dibit accepted on the last PRE cycle follow the SFD directly.
module fcs_append
  import eth_tx_pkg::*;
#(
  parameter int IFG_DIBITS = 48
`ifdef FCS_APPEND_PAD_EN
  ,
  parameter int MIN_PAYLOAD_DIBITS = 240
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiir,
  output logic       axiov,
  output logic [1:0] axiod
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_DIBITS - 1);
  localparam logic [7:0] FCS_LAST = 8'(FCS_DIBITS - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_DIBITS - 1);

  tx_state_t   state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [31:0] crc, crc_n, crc_step, fcs_word;
  logic [1:0]  step_din, od_n;
  logic [3:0]  fidx;
  logic        ov_n, start, end_payload, to_fcs;
`ifdef FCS_APPEND_PAD_EN
  localparam logic [7:0] MIN_LEN = 8'(MIN_PAYLOAD_DIBITS);
  logic [7:0]  pcnt, pcnt_n;
`endif

  // Pad dibits (DATA with axiiv low, or PAD) fold in as zeros.
  assign step_din = (axiiv && (state == S_PRE || state == S_DATA)) ? axiid : 2'b00;
  assign fcs_word = ~crc;
  assign fidx     = cnt[3:0] + 4'd1;

  crc32_dibit_step u_step (
    .crc      (crc),
    .dibit    (step_din),
    .crc_next (crc_step)
  );

  // State, counters, CRC and registered TX outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
      crc   <= ETH_CRC_INIT;
      axiov <= 1'b0;
      axiod <= 2'b00;
`ifdef FCS_APPEND_PAD_EN
      pcnt  <= 8'd0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      crc   <= crc_n;
      axiov <= ov_n;
      axiod <= od_n;
`ifdef FCS_APPEND_PAD_EN
      pcnt  <= pcnt_n;
`endif
    end
  end

  // Next-state, ready and next output dibit.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    crc_n       = crc;
    ov_n        = 1'b0;
    od_n        = 2'b00;
    axiir       = 1'b0;
    start       = 1'b0;
    end_payload = 1'b0;
    to_fcs      = 1'b0;
`ifdef FCS_APPEND_PAD_EN
    pcnt_n      = pcnt;
`endif
    case (state)
      S_IDLE: start = axiiv;
      S_PRE: begin
        ov_n = 1'b1;
        if (cnt == PRE_LAST) begin
          axiir = 1'b1;
          if (axiiv) begin
            state_n = S_DATA;
            od_n    = axiid;
            crc_n   = crc_step;
`ifdef FCS_APPEND_PAD_EN
            pcnt_n  = (pcnt == 8'hFF) ? pcnt : pcnt + 8'd1;
`endif
          end else begin
            end_payload = 1'b1;
          end
        end else begin
          cnt_n = cnt + 8'd1;
          od_n  = (cnt == PRE_LAST - 8'd1) ? 2'b11 : 2'b01;
        end
      end
      S_DATA: begin
        axiir = 1'b1;
        ov_n  = 1'b1;
        if (axiiv) begin
          od_n   = axiid;
          crc_n  = crc_step;
`ifdef FCS_APPEND_PAD_EN
          pcnt_n = (pcnt == 8'hFF) ? pcnt : pcnt + 8'd1;
`endif
        end else begin
          end_payload = 1'b1;
        end
      end
`ifdef FCS_APPEND_PAD_EN
      S_PAD: begin
        ov_n = 1'b1;
        if (pcnt == MIN_LEN) begin
          to_fcs = 1'b1;
        end else begin
          od_n   = 2'b00;
          crc_n  = crc_step;
          pcnt_n = pcnt + 8'd1;
        end
      end
`endif
      S_FCS: begin
        if (cnt == FCS_LAST) begin
          state_n = S_IFG;
          cnt_n   = 8'd0;
        end else begin
          ov_n  = 1'b1;
          cnt_n = cnt + 8'd1;
          od_n  = fcs_word[{fidx, 1'b0} +: 2];
        end
      end
      S_IFG: begin
        // The IDLE decision is taken on the last gap cycle so a waiting
        // source sees exactly IFG_DIBITS idle cycles.
        if (cnt == IFG_LAST) begin
          if (axiiv) start = 1'b1;
          else       state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (end_payload) begin
`ifdef FCS_APPEND_PAD_EN
      if (pcnt < MIN_LEN) begin
        state_n = S_PAD;
        ov_n    = 1'b1;
        od_n    = 2'b00;
        crc_n   = crc_step;
        pcnt_n  = pcnt + 8'd1;
      end else begin
        to_fcs = 1'b1;
      end
`else
      to_fcs = 1'b1;
`endif
    end

    if (to_fcs) begin
      state_n = S_FCS;
      cnt_n   = 8'd0;
      ov_n    = 1'b1;
      od_n    = fcs_word[1:0];
    end

    if (start) begin
      state_n = S_PRE;
      cnt_n   = 8'd0;
      crc_n   = ETH_CRC_INIT;
      ov_n    = 1'b1;
      od_n    = 2'b01;
`ifdef FCS_APPEND_PAD_EN
      pcnt_n  = 8'd0;
`endif
    end
  end

endmodule

// File: tb/tb_fcs_append.sv
// Testbench for fcs_append: byte-level reference framer (preamble, payload,
// optional zero padding, CRC-32 FCS) compared against the captured TX stream.
module tb_fcs_append;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic       axiir, axiov;
  logic [1:0] axiod;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fcs_append dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiir (axiir),
    .axiov (axiov),
    .axiod (axiod)
  );

  // Output monitor: collects each contiguous axiov run as one frame.
  logic [1:0] cur[$];
  logic [1:0] last_frame[$];
  logic [1:0] exp_q[$];
  int frames_done = 0;
  int gap = 0;
  int last_gap = 0;
  bit in_frame = 0;

  always @(posedge clk) begin
    #1;
    if (axiov === 1'b1) begin
      if (!in_frame) begin
        last_gap = gap;
        cur.delete();
        in_frame = 1;
      end
      cur.push_back(axiod);
      gap = 0;
    end else begin
      if (in_frame) begin
        last_frame = cur;
        frames_done++;
        in_frame = 0;
      end
      gap++;
    end
  end

  // Reference frame from payload bytes.
  function automatic void build_expected(input logic [7:0] pl[$]);
    logic [7:0]  b[$];
    logic [31:0] c, f;
    logic [7:0]  x;
    b = pl;
`ifdef FCS_APPEND_PAD_EN
    while (b.size() < 60) b.push_back(8'h00);
`endif
    exp_q.delete();
    for (int i = 0; i < 31; i++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      x = b[i];
      for (int k = 0; k < 4; k++) exp_q.push_back(x[2*k +: 2]);
      c = c ^ {24'd0, x};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    f = ~c;
    for (int k = 0; k < 16; k++) exp_q.push_back(f[2*k +: 2]);
  endfunction

  function automatic int first_diff();
    int n;
    n = (last_frame.size() < exp_q.size()) ? last_frame.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (last_frame[i] !== exp_q[i]) return i;
    if (last_frame.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [31:0] rx_fcs();
    logic [31:0] f;
    int n;
    f = 32'd0;
    n = last_frame.size();
    if (n >= 16) for (int k = 0; k < 16; k++) f[2*k +: 2] = last_frame[n-16+k];
    return f;
  endfunction

  // Source: axiiv held high for the payload, dropped once at end; optional
  // hold-high afterwards; optional early stop after abort_at transfers.
  task automatic send(input logic [7:0] pl[$], input bit hold, input int abort_at,
                      output bit ok);
    logic [1:0] d[$];
    logic [7:0] x;
    int idx, n, fd0;
    bit ended, rdy;
    d.delete();
    foreach (pl[i]) begin
      x = pl[i];
      for (int k = 0; k < 4; k++) d.push_back(x[2*k +: 2]);
    end
    n = d.size();
    fd0 = frames_done;
    idx = 0;
    ended = 0;
    ok = 0;
    for (int c = 0; c < 3000 && !ended; c++) begin
      axiiv = (idx < n) || !axiir;
      axiid = (idx < n) ? d[idx] : 2'($urandom);
      rdy = axiir;
      @(posedge clk);
      #2;
      if (rdy && axiiv) begin
        idx++;
        if (idx == abort_at) begin
          ok = 1;
          return;
        end
      end else if (rdy) begin
        ended = 1;
      end
    end
    if (!ended) return;
    axiiv = hold;
    for (int c = 0; c < 400 && frames_done == fd0; c++) begin
      @(posedge clk);
      #2;
    end
    ok = (frames_done != fd0);
  endtask

  function automatic void rand_payload(output logic [7:0] pl[$], input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endfunction

  function automatic void ascii_check(output logic [7:0] pl[$]);
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    axiiv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (axiov !== 1'b0) begin failures++; $display("FAIL reset_axiov: got %b expected 0", axiov); end
      checks++;
      if (axiod !== 2'b00) begin failures++; $display("FAIL reset_axiod: got %b expected 00", axiod); end
      checks++;
      if (axiir !== 1'b0) begin failures++; $display("FAIL reset_axiir: got %b expected 0", axiir); end
    end
    axiiv = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_known();
    logic [7:0] pl[$];
    bit ok;
    int m;
    ascii_check(pl);
    build_expected(pl);
    send(pl, 0, -1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL known_timeout: got no frame expected one"); end
    checks++;
    if (last_frame.size() !== exp_q.size()) begin
      failures++; $display("FAIL known_len: got %0d expected %0d", last_frame.size(), exp_q.size());
    end
    m = first_diff();
    checks++;
    if (m !== -1) begin failures++; $display("FAIL known_dibits: first difference at %0d expected none", m); end
`ifndef FCS_APPEND_PAD_EN
    checks++;
    if (rx_fcs() !== 32'hCBF4_3926) begin
      failures++; $display("FAIL known_fcs: got %08h expected cbf43926", rx_fcs());
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] pl[$];
    bit ok;
    int m;
    for (int t = 0; t < 5; t++) begin
      rand_payload(pl, $urandom_range(1, 24));
      build_expected(pl);
      send(pl, 0, -1, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL random_timeout[%0d]: got no frame expected one", t); end
      m = first_diff();
      checks++;
      if (m !== -1) begin
        failures++;
        $display("FAIL random_frame[%0d]: got size %0d diff at %0d expected size %0d no diff",
                 t, last_frame.size(), m, exp_q.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pl[$];
    bit ok;
    int m;
    rand_payload(pl, $urandom_range(2, 12));
    build_expected(pl);
    send(pl, 1, -1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_first_timeout: got no frame expected one"); end
    m = first_diff();
    checks++;
    if (m !== -1) begin failures++; $display("FAIL b2b_first_frame: diff at %0d expected none", m); end
    rand_payload(pl, $urandom_range(2, 12));
    build_expected(pl);
    send(pl, 0, -1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_second_timeout: got no frame expected one"); end
    m = first_diff();
    checks++;
    if (m !== -1) begin failures++; $display("FAIL b2b_second_frame: diff at %0d expected none", m); end
    checks++;
    if (last_gap !== 48) begin failures++; $display("FAIL b2b_gap: got %0d expected 48", last_gap); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pl[$];
    bit ok;
    int m;
    rand_payload(pl, 8);
    send(pl, 0, 10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midrst_reach: got no 10th transfer expected one"); end
    rst = 1'b0;
    #1;
    checks++;
    if (axiov !== 1'b0) begin failures++; $display("FAIL midrst_axiov: got %b expected 0", axiov); end
    checks++;
    if (axiod !== 2'b00) begin failures++; $display("FAIL midrst_axiod: got %b expected 00", axiod); end
    checks++;
    if (axiir !== 1'b0) begin failures++; $display("FAIL midrst_axiir: got %b expected 0", axiir); end
    axiiv = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2;
    ascii_check(pl);
    build_expected(pl);
    send(pl, 0, -1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midrst_next_timeout: got no frame expected one"); end
    m = first_diff();
    checks++;
    if (m !== -1) begin failures++; $display("FAIL midrst_next_frame: diff at %0d expected none", m); end
`ifndef FCS_APPEND_PAD_EN
    checks++;
    if (rx_fcs() !== 32'hCBF4_3926) begin
      failures++; $display("FAIL midrst_next_fcs: got %08h expected cbf43926", rx_fcs());
    end
`endif
  endtask

  task automatic test_zero_len();
    logic [7:0] pl[$];
    bit ok;
    int m;
    pl.delete();
    build_expected(pl);
    send(pl, 0, -1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL zero_timeout: got no frame expected one"); end
    m = first_diff();
    checks++;
    if (m !== -1) begin failures++; $display("FAIL zero_frame: diff at %0d expected none", m); end
`ifndef FCS_APPEND_PAD_EN
    checks++;
    if (rx_fcs() !== 32'h0000_0000 || last_frame.size() !== 48) begin
      failures++;
      $display("FAIL zero_fcs: got fcs %08h len %0d expected 00000000 len 48", rx_fcs(), last_frame.size());
    end
`endif
  endtask

  task automatic test_pad();
    logic [7:0] pl[$];
    bit ok;
    int m, want;
    pl.delete();
    pl.push_back(8'h00);
    build_expected(pl);
    send(pl, 0, -1, ok);
`ifdef FCS_APPEND_PAD_EN
    want = 32 + 240 + 16;
`else
    want = 32 + 4 + 16;
`endif
    checks++;
    if (!ok) begin failures++; $display("FAIL pad_timeout: got no frame expected one"); end
    checks++;
    if (last_frame.size() !== want) begin
      failures++; $display("FAIL pad_len: got %0d expected %0d", last_frame.size(), want);
    end
    m = first_diff();
    checks++;
    if (m !== -1) begin failures++; $display("FAIL pad_frame: diff at %0d expected none", m); end
  endtask

  initial begin
    test_reset();
    test_known();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_zero_len();
    test_pad();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
